// File: rtl/cla16_addsub_pipe_pkg.sv
// Shared constants, stage-1 bundle and intra-group carry helper
// for the 16-bit pipelined lookahead adder/subtractor.
package cla16_addsub_pipe_pkg;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = 4;

  typedef struct packed {
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   g;
    logic [NGROUPS-1:0] P;
    logic [NGROUPS-1:0] G;
    logic               c0;
    logic               a_msb;
    logic               b_msb;
  } s1_t;

  // Carries into bits 0..3 of one group, flat sums of products.
  function automatic logic [3:0] grp_carry(
    input logic [3:0] p,
    input logic [3:0] g,
    input logic       ci
  );
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

endpackage

// File: rtl/cla16_addsub_pipe_lookahead_carry_unit.sv
// One-level lookahead over four groups: group carries plus
// section P*/G* for cascading into a wider adder.
module lookahead_carry_unit (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       c0,
  output logic [4:1] c,
  output logic       pstar,
  output logic       gstar
);

  assign c[1] = g[0] | (p[0] & c0);

  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c0);

  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);

  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

  assign pstar = &p;

  assign gstar = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla16_addsub_pipe.sv
// Two-stage 16-bit CLA add/sub: stage 1 registers bit and group P/G,
// stage 2 resolves carries and registers result and flags.
module cla16_addsub_pipe
  import cla16_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [WIDTH-1:0]   bb;
  logic [WIDTH-1:0]   pb;
  logic [WIDTH-1:0]   gb;
  logic [NGROUPS-1:0] grp_p;
  logic [NGROUPS-1:0] grp_g;

  assign bb = sub ? ~b : b;
  assign pb = a ^ bb;
  assign gb = a & bb;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_pg
    logic [GROUP-1:0] pk;
    logic [GROUP-1:0] gk;
    assign pk = pb[k*GROUP +: GROUP];
    assign gk = gb[k*GROUP +: GROUP];
    assign grp_p[k] = &pk;
    assign grp_g[k] = gk[3]
                    | (pk[3] & gk[2])
                    | (pk[3] & pk[2] & gk[1])
                    | (pk[3] & pk[2] & pk[1] & gk[0]);
  end

  s1_t s1_d;
  s1_t s1_q;

  always_comb begin
    s1_d       = '0;
    s1_d.p     = pb;
    s1_d.g     = gb;
    s1_d.P     = grp_p;
    s1_d.G     = grp_g;
    s1_d.c0    = sub;
    s1_d.a_msb = a[WIDTH-1];
    s1_d.b_msb = bb[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [4:1] gc;
  logic       pstar;
  logic       gstar;

  lookahead_carry_unit u_lcu (
    .p     (s1_q.P),
    .g     (s1_q.G),
    .c0    (s1_q.c0),
    .c     (gc),
    .pstar (pstar),
    .gstar (gstar)
  );

  logic [NGROUPS:0] cin;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;

  assign cin = {gc, s1_q.c0};

  for (genvar k = 0; k < NGROUPS; k++) begin : g_sum
    assign carry[k*GROUP +: GROUP] = grp_carry(
      s1_q.p[k*GROUP +: GROUP],
      s1_q.g[k*GROUP +: GROUP],
      cin[k]
    );
  end

  assign sum = s1_q.p ^ carry;

  // Group MSB generates and section P*/G* only matter when cascaded.
  logic unused_cascade;
  assign unused_cascade = ^{pstar, gstar,
                            s1_q.g[15], s1_q.g[11],
                            s1_q.g[7], s1_q.g[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= sum;
        cout   <= gc[4];
        ovf    <= (s1_q.a_msb == s1_q.b_msb)
               && (sum[WIDTH-1] != s1_q.a_msb);
        zero   <= ~|sum;
      end
    end
  end

endmodule
